load_store_unit: RTL and testbench

//  Multi-cycle initiator for the data memory port. Takes one load/store request per transaction from the datapath.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_addr_gen.sv | 21 ++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding and memory geometry.
package lsu_pkg;

   // Default data memory size in bytes and the width of one memory word.
   localparam int unsigned MEM_BYTES_DEFAULT = 1024;
   localparam int unsigned WORD_BYTES        = 4;
   localparam int unsigned ALIGN_BITS        = $clog2(WORD_BYTES);

   // Two-bit state encodings, kept as named constants so other blocks can decode them.
   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_CALC_ENC   = 2'd1;
   localparam logic [1:0] ST_ACCESS_ENC = 2'd2;
   localparam logic [1:0] ST_DONE_ENC   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE_ENC,
      CALC   = ST_CALC_ENC,
      ACCESS = ST_ACCESS_ENC,
      DONE   = ST_DONE_ENC
   } lsu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective-address generator: base + sign-extended imm16, with alignment and range checks.
module lsu_addr_gen
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic [31:0] base_i,
   input  logic [15:0] imm16_i,
   output logic [31:0] ea_o,
   output logic        misaligned_o,
   output logic        out_of_range_o
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   // The add wraps modulo 2^32 by construction; wrap-around is a legal address, not a fault.
   assign ea_o           = base_i + {{16{imm16_i[15]}}, imm16_i};
   assign misaligned_o   = (ea_o[ALIGN_BITS-1:0] != '0);
   assign out_of_range_o = (ea_o >= MEM_LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory port.
// One request per transaction: IDLE -> CALC -> (ACCESS) -> DONE -> IDLE.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_lsu,
   input  logic        lsu_req,
   output logic        lsu_ready,
   input  logic        lsu_is_store,
   input  logic [31:0] lsu_base,
   input  logic [15:0] lsu_imm16,
   input  logic [31:0] lsu_store_data,
   output logic        lsu_done,
   output logic [31:0] lsu_load_data,
   output logic        lsu_misaligned,
   output logic        lsu_out_of_range,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_write_data,
   output logic        ctrl_dataMem_Write,
   output logic        ctrl_dataMem2reg,
   input  logic [31:0] dm_read_data
);

   lsu_state_e  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [31:0] base_q, base_d;
   logic [15:0] imm_q, imm_d;
   logic [31:0] store_data_q, store_data_d;
   logic [31:0] ea_q, ea_d;
   logic        mis_q, mis_d;
   logic        oor_q, oor_d;
   logic [31:0] load_data_q, load_data_d;

   logic [31:0] ea_calc;
   logic        mis_calc;
   logic        oor_calc;

   lsu_addr_gen #(
      .MEM_BYTES (MEM_BYTES)
   ) u_addr_gen (
      .base_i         (base_q),
      .imm16_i        (imm_q),
      .ea_o           (ea_calc),
      .misaligned_o   (mis_calc),
      .out_of_range_o (oor_calc)
   );

   // State and datapath registers; reset aborts any transaction immediately.
   // NOTE: non-blocking assignments here so every register samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk or posedge rst_lsu) begin
      if (rst_lsu) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         base_q       <= '0;
         imm_q        <= '0;
         store_data_q <= '0;
         ea_q         <= '0;
         mis_q        <= 1'b0;
         oor_q        <= 1'b0;
         load_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         base_q       <= base_d;
         imm_q        <= imm_d;
         store_data_q <= store_data_d;
         ea_q         <= ea_d;
         mis_q        <= mis_d;
         oor_q        <= oor_d;
         load_data_q  <= load_data_d;
      end
   end

   // Next-state logic and output decode; strobes depend only on registered state and data.
   // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d            = state_q;
      is_store_d         = is_store_q;
      base_d             = base_q;
      imm_d              = imm_q;
      store_data_d       = store_data_q;
      ea_d               = ea_q;
      mis_d              = mis_q;
      oor_d              = oor_q;
      load_data_d        = load_data_q;

      lsu_ready          = 1'b0;
      lsu_done           = 1'b0;
      lsu_misaligned     = 1'b0;
      lsu_out_of_range   = 1'b0;
      dm_addr            = '0;
      dm_write_data      = '0;
      ctrl_dataMem_Write = 1'b0;
      ctrl_dataMem2reg   = 1'b0;

      unique case (state_q)
         IDLE: begin
            lsu_ready = 1'b1;
            if (lsu_req) begin
               is_store_d   = lsu_is_store;
               base_d       = lsu_base;
               imm_d        = lsu_imm16;
               store_data_d = lsu_store_data;
               state_d      = CALC;
            end
         end
         CALC: begin
            ea_d    = ea_calc;
            mis_d   = mis_calc;
            oor_d   = oor_calc;
            // A faulted access never reaches the memory port.
            state_d = (mis_calc || oor_calc) ? DONE : ACCESS;
         end
         ACCESS: begin
            dm_addr = ea_q;
            if (is_store_q) begin
               ctrl_dataMem_Write = 1'b1;
               dm_write_data      = store_data_q;
            end else begin
               ctrl_dataMem2reg = 1'b1;
               load_data_d      = dm_read_data;
            end
            state_d = DONE;
         end
         DONE: begin
            lsu_done         = 1'b1;
            lsu_misaligned   = mis_q;
            lsu_out_of_range = oor_q;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign lsu_load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word-addressed data memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk;
   logic        rst_lsu;
   logic        lsu_req;
   logic        lsu_ready;
   logic        lsu_is_store;
   logic [31:0] lsu_base;
   logic [15:0] lsu_imm16;
   logic [31:0] lsu_store_data;
   logic        lsu_done;
   logic [31:0] lsu_load_data;
   logic        lsu_misaligned;
   logic        lsu_out_of_range;
   logic [31:0] dm_addr;
   logic [31:0] dm_write_data;
   logic        ctrl_dataMem_Write;
   logic        ctrl_dataMem2reg;
   logic [31:0] dm_read_data;

   int n_checks = 0;
   int n_errors = 0;

   // Data memory model: 256 words, combinational read, write on rising edge.
   logic [31:0] mem [0:255];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_data;

   assign dm_read_data = mem[dm_addr[9:2]];

   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      if (ctrl_dataMem_Write) mem[dm_addr[9:2]] <= dm_write_data;
   end

   // Per-cycle observation patterns of the last transaction (bit c-1 = cycle c after accept).
   logic [7:0]  pat_wr, pat_rd, pat_done, pat_rdy, pat_mis, pat_oor;
   logic [31:0] acc_addr, acc_wdata;

   load_store_unit #(.MEM_BYTES(1024)) dut (
      .clk                (clk),
      .rst_lsu            (rst_lsu),
      .lsu_req            (lsu_req),
      .lsu_ready          (lsu_ready),
      .lsu_is_store       (lsu_is_store),
      .lsu_base           (lsu_base),
      .lsu_imm16          (lsu_imm16),
      .lsu_store_data     (lsu_store_data),
      .lsu_done           (lsu_done),
      .lsu_load_data      (lsu_load_data),
      .lsu_misaligned     (lsu_misaligned),
      .lsu_out_of_range   (lsu_out_of_range),
      .dm_addr            (dm_addr),
      .dm_write_data      (dm_write_data),
      .ctrl_dataMem_Write (ctrl_dataMem_Write),
      .ctrl_dataMem2reg   (ctrl_dataMem2reg),
      .dm_read_data       (dm_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   // Issue one request and sample the outputs in the middle of each following cycle.
   task automatic run_txn(input logic st, input logic [31:0] base, input logic [15:0] imm,
                          input logic [31:0] data, input bit hold, input int ncyc);
      @(negedge clk);
      lsu_req        = 1'b1;
      lsu_is_store   = st;
      lsu_base       = base;
      lsu_imm16      = imm;
      lsu_store_data = data;
      pat_wr = '0; pat_rd = '0; pat_done = '0; pat_rdy = '0; pat_mis = '0; pat_oor = '0;
      acc_addr = '0; acc_wdata = '0;
      @(posedge clk);
      if (!hold) #1 lsu_req = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (hold && c == 5) lsu_req = 1'b0;
         pat_wr[c-1]   = ctrl_dataMem_Write;
         pat_rd[c-1]   = ctrl_dataMem2reg;
         pat_done[c-1] = lsu_done;
         pat_rdy[c-1]  = lsu_ready;
         pat_mis[c-1]  = lsu_misaligned;
         pat_oor[c-1]  = lsu_out_of_range;
         if (ctrl_dataMem_Write || ctrl_dataMem2reg) begin
            acc_addr  = dm_addr;
            acc_wdata = dm_write_data;
         end
      end
   endtask

   initial begin
      int done_seen;
      int wr_seen;
      rst_lsu        = 1'b1;
      lsu_req        = 1'b0;
      lsu_is_store   = 1'b0;
      lsu_base       = '0;
      lsu_imm16      = '0;
      lsu_store_data = '0;
      pre_we         = 1'b0;
      pre_idx        = '0;
      pre_data       = '0;

      // Reset state
      #2;
      check("rst_ready", lsu_ready, 1);
      check("rst_done", lsu_done, 0);
      check("rst_load_data", lsu_load_data, 0);
      check("rst_write", ctrl_dataMem_Write, 0);
      check("rst_read", ctrl_dataMem2reg, 0);
      check("rst_addr", dm_addr, 0);
      check("rst_wdata", dm_write_data, 0);
      check("rst_flags", {lsu_misaligned, lsu_out_of_range}, 0);
      repeat (2) @(negedge clk);
      rst_lsu = 1'b0;

      preload(8'd4,  32'hA5A5_A5A5);
      preload(8'd7,  32'h1234_5678);
      preload(8'd1,  32'hCAFE_0001);
      preload(8'd12, 32'h7777_7777);

      // 1: store 0x10+4
      run_txn(1'b1, 32'h10, 16'h0004, 32'hDEAD_BEEF, 1'b0, 4);
      check("t1_wr_pat", pat_wr, 8'h02);
      check("t1_rd_pat", pat_rd, 8'h00);
      check("t1_addr", acc_addr, 32'h14);
      check("t1_wdata", acc_wdata, 32'hDEAD_BEEF);
      check("t1_done_pat", pat_done, 8'h04);
      check("t1_rdy_pat", pat_rdy, 8'h08);
      check("t1_flags", {pat_mis, pat_oor}, 16'h0);
      check("t1_mem", mem[5], 32'hDEAD_BEEF);
      check("t1_load_data", lsu_load_data, 0);

      // 2: load back 0x14
      run_txn(1'b0, 32'h10, 16'h0004, 32'h0, 1'b0, 4);
      check("t2_rd_pat", pat_rd, 8'h02);
      check("t2_wr_pat", pat_wr, 8'h00);
      check("t2_addr", acc_addr, 32'h14);
      check("t2_done_pat", pat_done, 8'h04);
      check("t2_load_data", lsu_load_data, 32'hDEAD_BEEF);

      // 3a: negative offset 0x20-4
      run_txn(1'b0, 32'h20, 16'hFFFC, 32'h0, 1'b0, 4);
      check("t3a_addr", acc_addr, 32'h1C);
      check("t3a_load_data", lsu_load_data, 32'h1234_5678);

      // 3b: address wrap 0xFFFFFFFC+8
      run_txn(1'b0, 32'hFFFF_FFFC, 16'h0008, 32'h0, 1'b0, 4);
      check("t3b_addr", acc_addr, 32'h4);
      check("t3b_rd_pat", pat_rd, 8'h02);
      check("t3b_done_pat", pat_done, 8'h04);
      check("t3b_flags", {pat_mis, pat_oor}, 16'h0);
      check("t3b_load_data", lsu_load_data, 32'hCAFE_0001);

      // 4: misaligned store
      run_txn(1'b1, 32'h13, 16'h0000, 32'h1111_1111, 1'b0, 4);
      check("t4_done_pat", pat_done, 8'h02);
      check("t4_mis_pat", pat_mis, 8'h02);
      check("t4_oor_pat", pat_oor, 8'h00);
      check("t4_wr_pat", pat_wr, 8'h00);
      check("t4_rdy_pat", pat_rdy, 8'h0C);
      check("t4_mem", mem[4], 32'hA5A5_A5A5);
      check("t4_load_data", lsu_load_data, 32'hCAFE_0001);

      // 5: out-of-range load
      run_txn(1'b0, 32'h400, 16'h0000, 32'h0, 1'b0, 4);
      check("t5_done_pat", pat_done, 8'h02);
      check("t5_oor_pat", pat_oor, 8'h02);
      check("t5_mis_pat", pat_mis, 8'h00);
      check("t5_rd_pat", pat_rd, 8'h00);
      check("t5_load_data", lsu_load_data, 32'hCAFE_0001);

      // 6a: request held high through a store; re-accepted on return to IDLE
      run_txn(1'b1, 32'h20, 16'h0000, 32'h0000_0055, 1'b1, 8);
      check("t6a_rdy_pat", pat_rdy, 8'h88);
      check("t6a_wr_pat", pat_wr, 8'h22);
      check("t6a_done_pat", pat_done, 8'h44);
      check("t6a_mem", mem[8], 32'h0000_0055);

      // 6b: reset during ACCESS of a store
      @(negedge clk);
      lsu_req        = 1'b1;
      lsu_is_store   = 1'b1;
      lsu_base       = 32'h30;
      lsu_imm16      = 16'h0000;
      lsu_store_data = 32'h9999_9999;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      @(posedge clk);
      #2;
      check("t6b_pre_wr", ctrl_dataMem_Write, 1);
      rst_lsu = 1'b1;
      #1;
      check("t6b_async_wr", ctrl_dataMem_Write, 0);
      check("t6b_async_addr", dm_addr, 0);
      check("t6b_load_clr", lsu_load_data, 0);
      check("t6b_ready", lsu_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst_lsu   = 1'b0;
      done_seen = 0;
      wr_seen   = 0;
      repeat (4) begin
         @(negedge clk);
         if (lsu_done) done_seen++;
         if (ctrl_dataMem_Write) wr_seen++;
      end
      check("t6b_no_done", done_seen, 0);
      check("t6b_no_wr", wr_seen, 0);
      check("t6b_mem", mem[12], 32'h7777_7777);
      check("t6b_ready_after", lsu_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
